apb_interconnect: RTL and testbench

Parametrised APB interconnect between the CPU APB master port and NUM_SLV peripheral slaves (CNT, TMR, APB2SPI, GPIO, and later additions). It decodes the slave index from the upper address bits and routes PSEL, PRDATA, PREADY and PSLVERR. It terminates unmapped accesses with an error response. It watches every access phase and aborts hung slaves with a timeout error, keeping sticky per-slave timeout flags and a saturating error counter.

---
 rtl/apb_interconnect_pkg.sv | 22 ++
 rtl/apb_interconnect_if.sv | 33 +++
 rtl/apb_interconnect_tmo_counter.sv | 31 +++
 rtl/apb_interconnect.sv | 131 +++++++++++++
 tb/tb_apb_interconnect.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_interconnect_pkg.sv
// Shared types and constants for the APB interconnect: FSM state encoding,
// slave slot indices and the decode-width helper.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    TMO_RESP = 2'd2
  } apb_state_e;

  // Slot index of each peripheral; slot k starts at address k << SLV_SEL_B
  localparam int unsigned SLV_CNT     = 0;
  localparam int unsigned SLV_TMR     = 1;
  localparam int unsigned SLV_APB2SPI = 2;
  localparam int unsigned SLV_GPIO    = 3;

  function automatic int unsigned idx_width(input int unsigned addr_w,
                                            input int unsigned sel_b);
    return addr_w - sel_b;
  endfunction

endpackage

// File: rtl/apb_interconnect_if.sv
// Bundles the CPU-side APB port, the per-slave return buses and the
// timeout/error status signals of the interconnect.
interface apb_interconnect_if #(
  parameter int APB_ADDR_W = 16,
  parameter int NUM_SLV    = 4
);
  logic [APB_ADDR_W-1:0] paddr;
  logic                  psel_cpu;
  logic                  penable_cpu;
  logic [32*NUM_SLV-1:0] prdata_slv;
  logic [NUM_SLV-1:0]    pready_slv;
  logic [NUM_SLV-1:0]    pslverr_slv;
  logic                  clr_tmo;
  logic [NUM_SLV-1:0]    psel_slv;
  logic [31:0]           prdata_cpu;
  logic                  pready_cpu;
  logic                  pslverr_cpu;
  logic [NUM_SLV-1:0]    tmo_slv;
  logic                  tmo_irq;
  logic [15:0]           err_cnt;

  // The interconnect itself
  modport slave (
    input  paddr, psel_cpu, penable_cpu, prdata_slv, pready_slv, pslverr_slv, clr_tmo,
    output psel_slv, prdata_cpu, pready_cpu, pslverr_cpu, tmo_slv, tmo_irq, err_cnt
  );

  // The surrounding system: CPU master plus the peripherals
  modport master (
    output paddr, psel_cpu, penable_cpu, prdata_slv, pready_slv, pslverr_slv, clr_tmo,
    input  psel_slv, prdata_cpu, pready_cpu, pslverr_cpu, tmo_slv, tmo_irq, err_cnt
  );
endinterface

// File: rtl/apb_interconnect_tmo_counter.sv
// Access-phase wait counter; flags the wait cycle that exhausts the
// TMO_CYC budget. A TMO_CYC of 0 never expires.
module apb_tmo_counter #(
  parameter int TMO_CYC = 255,
  parameter int TMO_W   = 8
) (
  input  logic pclk,
  input  logic presetn,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);
  localparam logic             ENABLE = (TMO_CYC != 0);
  localparam logic [TMO_W-1:0] LIMIT  = (TMO_CYC == 0) ? '0 : TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] r_cnt;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + TMO_W'(1);
    end
  end

  // Expiry is the wait cycle in which the count already equals TMO_CYC-1
  assign o_expire = ENABLE && i_inc && (r_cnt == LIMIT);

endmodule

// File: rtl/apb_interconnect.sv
// APB interconnect: decodes the slave slot from the upper address bits, routes
// the response, errors unmapped accesses and aborts hung slaves on timeout.
module apb_interconnect
  import apb_pkg::*;
#(
  parameter int APB_ADDR_W = 16,
  parameter int NUM_SLV    = 4,
  parameter int SLV_SEL_B  = 11,
  parameter int TMO_CYC    = 255,
  parameter int TMO_W      = 8
) (
  input  logic               pclk,
  input  logic               presetn,
  apb_interconnect_if.slave  bus
);
  localparam int IDX_W = int'(idx_width(APB_ADDR_W, SLV_SEL_B));

  apb_state_e         r_state;
  apb_state_e         w_next;
  logic [NUM_SLV-1:0] r_tmo_slv;
  logic               r_tmo_irq;
  logic [15:0]        r_err_cnt;

  logic [IDX_W-1:0]   w_idx;
  logic               w_mapped;
  logic [NUM_SLV-1:0] w_hit;
  logic               w_rdy;
  logic               w_err;
  logic [31:0]        w_rdata;
  logic               w_pready;
  logic               w_pslverr;
  logic [31:0]        w_prdata;
  logic               w_inc;
  logic               w_cnt_clr;
  logic               w_expire;
  logic               w_to_tmo;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_idx    = bus.paddr[APB_ADDR_W-1:SLV_SEL_B];
  assign w_mapped = ({1'b0, w_idx} < (IDX_W+1)'(NUM_SLV));

  always_comb begin
    w_hit   = '0;
    w_rdy   = 1'b0;
    w_err   = 1'b0;
    w_rdata = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (w_idx == IDX_W'(k)) begin
        w_hit[k] = 1'b1;
        w_rdy    = bus.pready_slv[k];
        w_err    = bus.pslverr_slv[k];
        w_rdata  = bus.prdata_slv[32*k +: 32];
      end
    end
  end

  // Counter control lives outside the FSM block so expire never feeds back into it
  assign w_inc     = (r_state == ACCESS) && bus.psel_cpu && bus.penable_cpu &&
                     w_mapped && !w_rdy;
  assign w_cnt_clr = (r_state != ACCESS) || !bus.psel_cpu;

  apb_tmo_counter #(
    .TMO_CYC (TMO_CYC),
    .TMO_W   (TMO_W)
  ) u_tmo_counter (
    .pclk     (pclk),
    .presetn  (presetn),
    .i_clr    (w_cnt_clr),
    .i_inc    (w_inc),
    .o_expire (w_expire)
  );

  always_comb begin
    w_next    = r_state;
    w_pready  = 1'b0;
    w_pslverr = 1'b0;
    w_prdata  = '0;
    case (r_state)
      IDLE: begin
        if (bus.psel_cpu && !bus.penable_cpu) w_next = ACCESS;
      end
      ACCESS: begin
        if (w_mapped) begin
          w_pready  = bus.penable_cpu && w_rdy;
          w_pslverr = bus.penable_cpu && w_err;
          w_prdata  = bus.penable_cpu ? w_rdata : '0;
        end else begin
          w_pready  = bus.penable_cpu;
          w_pslverr = bus.penable_cpu;
        end
        if (!bus.psel_cpu || w_pready) w_next = IDLE;
        else if (w_expire)             w_next = TMO_RESP;
      end
      TMO_RESP: begin
        w_pready  = 1'b1;
        w_pslverr = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_to_tmo = (r_state == ACCESS) && (w_next == TMO_RESP);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= IDLE;
      r_tmo_slv <= '0;
      r_tmo_irq <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_next;
      r_tmo_irq <= w_to_tmo;
      // A new timeout survives a simultaneous clear for its own bit
      r_tmo_slv <= (bus.clr_tmo ? '0 : r_tmo_slv) | (w_to_tmo ? w_hit : '0);
      if (w_pready && w_pslverr) r_err_cnt <= sat_inc(r_err_cnt);
    end
  end

  assign bus.psel_slv    = (presetn && bus.psel_cpu && (r_state != TMO_RESP)) ? w_hit : '0;
  assign bus.pready_cpu  = presetn && w_pready;
  assign bus.pslverr_cpu = presetn && w_pslverr;
  assign bus.prdata_cpu  = presetn ? w_prdata : '0;
  assign bus.tmo_slv     = r_tmo_slv;
  assign bus.tmo_irq     = r_tmo_irq;
  assign bus.err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_apb_interconnect.sv
// Self-checking bench for apb_interconnect: directed scenarios plus randomized
// transfers checked against a transfer-level model of decode, timeout and errors.
module tb_apb_interconnect;
  localparam int TMO = 8;

  logic pclk = 1'b0;
  logic presetn;
  int   checks = 0;
  int   errors = 0;
  int   irq_seen = 0;
  int   m_err = 0;
  logic [3:0] m_tmo = '0;

  typedef struct {
    logic [3:0]  sel_setup;
    int          cycles;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  sel_last;
  } xobs_t;

  always #5 pclk = ~pclk;

  apb_interconnect_if #(.APB_ADDR_W(16), .NUM_SLV(4)) bus ();

  apb_interconnect #(
    .APB_ADDR_W (16),
    .NUM_SLV    (4),
    .SLV_SEL_B  (11),
    .TMO_CYC    (TMO),
    .TMO_W      (8)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  always @(negedge pclk) if (bus.tmo_irq === 1'b1) irq_seen++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "time limit");
  end

  // Reference rules for one transfer, from the address map and timeout budget
  function automatic bit is_mapped(input logic [15:0] a);
    return a[15:11] < 5'd4;
  endfunction
  function automatic int exp_cycles(input logic [15:0] a, input int ws);
    if (!is_mapped(a)) return 1;
    if (ws >= TMO) return TMO + 1;
    return ws + 1;
  endfunction
  function automatic logic [3:0] onehot(input logic [15:0] a);
    return is_mapped(a) ? (4'b0001 << a[12:11]) : 4'b0000;
  endfunction
  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : v[15:0];
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk); #1;
      bus.psel_cpu = 1'b0; bus.penable_cpu = 1'b0; bus.pready_slv = '0; bus.clr_tmo = 1'b0;
    end
    @(negedge pclk);
  endtask

  // Drives one setup + access sequence; slave k=target is ready after ws wait cycles
  task automatic run_xfer(input logic [15:0] addr, input int ws, input logic serr,
                          input logic [31:0] data, input int clr_n, output xobs_t o);
    int tgt;
    tgt = int'(addr[15:11]);
    o.sel_setup = 'x; o.cycles = 0; o.err = 'x; o.rdata = 'x; o.sel_last = 'x;
    @(posedge pclk); #1;
    bus.paddr = addr; bus.psel_cpu = 1'b1; bus.penable_cpu = 1'b0; bus.clr_tmo = 1'b0;
    bus.pready_slv = 4'($urandom); bus.pslverr_slv = 4'($urandom);
    for (int j = 0; j < 4; j++) bus.prdata_slv[32*j +: 32] = $urandom;
    if (tgt < 4) bus.prdata_slv[32*tgt +: 32] = data;
    @(negedge pclk);
    o.sel_setup = bus.psel_slv;
    for (int n = 1; n <= 20; n++) begin
      @(posedge pclk); #1;
      bus.penable_cpu = 1'b1;
      bus.clr_tmo = (n == clr_n);
      bus.pready_slv = 4'($urandom); bus.pslverr_slv = 4'($urandom);
      if (tgt < 4) begin
        bus.pready_slv[tgt] = (n > ws);
        bus.pslverr_slv[tgt] = serr;
      end
      @(negedge pclk);
      if (bus.pready_cpu === 1'b1) begin
        o.cycles = n; o.err = bus.pslverr_cpu; o.rdata = bus.prdata_cpu; o.sel_last = bus.psel_slv;
        break;
      end
    end
  endtask

  task automatic test_reset;
    presetn = 1'b0;
    bus.paddr = 16'h0804; bus.psel_cpu = 1'b1; bus.penable_cpu = 1'b0; bus.clr_tmo = 1'b0;
    bus.pready_slv = '1; bus.pslverr_slv = '1; bus.prdata_slv = {4{32'hA5A5_5A5A}};
    repeat (2) @(negedge pclk);
    bus.penable_cpu = 1'b1;
    @(negedge pclk);
    checks++; if (bus.psel_slv !== 4'b0) begin errors++; $display("FAIL rst_psel: got %b expected 0000", bus.psel_slv); end
    checks++; if (bus.pready_cpu !== 1'b0) begin errors++; $display("FAIL rst_pready: got %b expected 0", bus.pready_cpu); end
    checks++; if (bus.pslverr_cpu !== 1'b0) begin errors++; $display("FAIL rst_pslverr: got %b expected 0", bus.pslverr_cpu); end
    checks++; if (bus.prdata_cpu !== 32'h0) begin errors++; $display("FAIL rst_prdata: got %h expected 0", bus.prdata_cpu); end
    checks++; if (bus.tmo_slv !== 4'b0) begin errors++; $display("FAIL rst_tmo_slv: got %b expected 0000", bus.tmo_slv); end
    checks++; if (bus.tmo_irq !== 1'b0) begin errors++; $display("FAIL rst_tmo_irq: got %b expected 0", bus.tmo_irq); end
    checks++; if (bus.err_cnt !== 16'h0) begin errors++; $display("FAIL rst_err_cnt: got %h expected 0", bus.err_cnt); end
    @(posedge pclk); #1;
    presetn = 1'b1; bus.psel_cpu = 1'b0; bus.penable_cpu = 1'b0; bus.pready_slv = '0;
    idle(1);
  endtask

  task automatic test_read;
    xobs_t o;
    run_xfer(16'h0804, 0, 1'b0, 32'hDEADBEEF, 0, o);
    checks++; if (o.sel_setup !== 4'b0010) begin errors++; $display("FAIL rd_sel_setup: got %b expected 0010", o.sel_setup); end
    checks++; if (o.cycles !== 1) begin errors++; $display("FAIL rd_cycles: got %0d expected 1", o.cycles); end
    checks++; if (o.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_prdata: got %h expected deadbeef", o.rdata); end
    checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL rd_pslverr: got %b expected 0", o.err); end
    checks++; if (o.sel_last !== 4'b0010) begin errors++; $display("FAIL rd_sel_access: got %b expected 0010", o.sel_last); end
    idle(1);
  endtask

  task automatic test_wait_states;
    xobs_t o;
    run_xfer(16'h1800, 3, 1'b0, 32'h1234_5678, 0, o);
    checks++; if (o.cycles !== 4) begin errors++; $display("FAIL ws3_cycles: got %0d expected 4", o.cycles); end
    checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL ws3_pslverr: got %b expected 0", o.err); end
    checks++; if (o.sel_last !== 4'b1000) begin errors++; $display("FAIL ws3_sel: got %b expected 1000", o.sel_last); end
    idle(1);
    checks++; if (bus.tmo_slv !== 4'b0) begin errors++; $display("FAIL ws3_tmo_slv: got %b expected 0000", bus.tmo_slv); end
  endtask

  task automatic test_unmapped;
    xobs_t o;
    run_xfer(16'h2000, 0, 1'b0, 32'hFFFF_FFFF, 0, o);
    m_err++;
    checks++; if (o.sel_setup !== 4'b0) begin errors++; $display("FAIL um_sel: got %b expected 0000", o.sel_setup); end
    checks++; if (o.cycles !== 1) begin errors++; $display("FAIL um_cycles: got %0d expected 1", o.cycles); end
    checks++; if (o.err !== 1'b1) begin errors++; $display("FAIL um_pslverr: got %b expected 1", o.err); end
    checks++; if (o.rdata !== 32'h0) begin errors++; $display("FAIL um_prdata: got %h expected 0", o.rdata); end
    idle(1);
    checks++; if (bus.err_cnt !== sat16(m_err)) begin errors++; $display("FAIL um_err_cnt: got %0d expected %0d", bus.err_cnt, sat16(m_err)); end
  endtask

  task automatic test_timeout;
    xobs_t o;
    int irq0;
    irq0 = irq_seen;
    run_xfer(16'h1000, 1000, 1'b0, 32'h0BAD_F00D, 0, o);
    m_err++; m_tmo[2] = 1'b1;
    checks++; if (o.cycles !== TMO + 1) begin errors++; $display("FAIL tmo_cycles: got %0d expected %0d", o.cycles, TMO + 1); end
    checks++; if (o.err !== 1'b1) begin errors++; $display("FAIL tmo_pslverr: got %b expected 1", o.err); end
    checks++; if (o.rdata !== 32'h0) begin errors++; $display("FAIL tmo_prdata: got %h expected 0", o.rdata); end
    checks++; if (o.sel_last !== 4'b0) begin errors++; $display("FAIL tmo_sel: got %b expected 0000", o.sel_last); end
    idle(2);
    checks++; if (bus.tmo_slv !== m_tmo) begin errors++; $display("FAIL tmo_flag: got %b expected %b", bus.tmo_slv, m_tmo); end
    checks++; if (irq_seen - irq0 !== 1) begin errors++; $display("FAIL tmo_irq_pulse: got %0d cycles expected 1", irq_seen - irq0); end
    checks++; if (bus.err_cnt !== sat16(m_err)) begin errors++; $display("FAIL tmo_err_cnt: got %0d expected %0d", bus.err_cnt, sat16(m_err)); end
    @(posedge pclk); #1; bus.clr_tmo = 1'b1;
    idle(1);
    m_tmo = '0;
    checks++; if (bus.tmo_slv !== 4'b0) begin errors++; $display("FAIL tmo_clear: got %b expected 0000", bus.tmo_slv); end
    irq0 = irq_seen;
    run_xfer(16'h1000, TMO - 1, 1'b0, 32'hC0FF_EE00, 0, o);
    checks++; if (o.cycles !== TMO) begin errors++; $display("FAIL late_cycles: got %0d expected %0d", o.cycles, TMO); end
    checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL late_pslverr: got %b expected 0", o.err); end
    checks++; if (o.rdata !== 32'hC0FF_EE00) begin errors++; $display("FAIL late_prdata: got %h expected c0ffee00", o.rdata); end
    idle(2);
    checks++; if (bus.tmo_slv !== 4'b0) begin errors++; $display("FAIL late_flag: got %b expected 0000", bus.tmo_slv); end
    checks++; if (irq_seen !== irq0) begin errors++; $display("FAIL late_irq: got %0d pulses expected 0", irq_seen - irq0); end
  endtask

  task automatic test_clr_collision;
    xobs_t o;
    run_xfer(16'h1400, 1000, 1'b0, 32'h0, 0, o);
    m_err++; m_tmo[2] = 1'b1;
    idle(1);
    checks++; if (bus.tmo_slv !== 4'b0100) begin errors++; $display("FAIL coll_pre: got %b expected 0100", bus.tmo_slv); end
    run_xfer(16'h0010, 1000, 1'b0, 32'h0, TMO, o);
    m_err++; m_tmo = 4'b0001;
    checks++; if (o.cycles !== TMO + 1) begin errors++; $display("FAIL coll_cycles: got %0d expected %0d", o.cycles, TMO + 1); end
    idle(1);
    checks++; if (bus.tmo_slv !== 4'b0001) begin errors++; $display("FAIL coll_flag: got %b expected 0001", bus.tmo_slv); end
  endtask

  task automatic test_back_to_back;
    xobs_t o;
    logic [15:0] a;
    logic [4:0]  ix;
    logic [31:0] d;
    logic        se, tmo_hit, mapped;
    int          ws, irq0, irq_exp;
    irq0 = irq_seen; irq_exp = 0;
    for (int t = 0; t < 40; t++) begin
      ix = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
      a  = {ix, 11'($urandom)};
      ws = $urandom_range(0, 10);
      se = 1'($urandom);
      d  = $urandom;
      mapped  = is_mapped(a);
      tmo_hit = mapped && (ws >= TMO);
      run_xfer(a, ws, se, d, 0, o);
      checks++; if (o.sel_setup !== onehot(a)) begin errors++; $display("FAIL b2b_sel[%0d]: got %b expected %b", t, o.sel_setup, onehot(a)); end
      checks++; if (o.cycles !== exp_cycles(a, ws)) begin errors++; $display("FAIL b2b_cycles[%0d]: got %0d expected %0d", t, o.cycles, exp_cycles(a, ws)); end
      checks++; if (o.err !== (!mapped || tmo_hit || se)) begin errors++; $display("FAIL b2b_err[%0d]: got %b expected %b", t, o.err, (!mapped || tmo_hit || se)); end
      checks++; if (o.rdata !== ((mapped && !tmo_hit) ? d : 32'h0)) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", t, o.rdata, ((mapped && !tmo_hit) ? d : 32'h0)); end
      if (!mapped || tmo_hit || se) m_err++;
      if (tmo_hit) begin m_tmo[ix[1:0]] = 1'b1; irq_exp++; end
      if ($urandom_range(0, 1) == 0) idle(1);
    end
    idle(2);
    checks++; if (bus.err_cnt !== sat16(m_err)) begin errors++; $display("FAIL b2b_err_cnt: got %0d expected %0d", bus.err_cnt, sat16(m_err)); end
    checks++; if (bus.tmo_slv !== m_tmo) begin errors++; $display("FAIL b2b_tmo_slv: got %b expected %b", bus.tmo_slv, m_tmo); end
    checks++; if (irq_seen - irq0 !== irq_exp) begin errors++; $display("FAIL b2b_irq: got %0d expected %0d", irq_seen - irq0, irq_exp); end
  endtask

  task automatic test_reset_mid;
    xobs_t o;
    @(posedge pclk); #1;
    bus.paddr = 16'h1800; bus.psel_cpu = 1'b1; bus.penable_cpu = 1'b0; bus.pready_slv = '0;
    repeat (4) begin @(posedge pclk); #1; bus.penable_cpu = 1'b1; end
    @(negedge pclk);
    checks++; if (bus.psel_slv !== 4'b1000) begin errors++; $display("FAIL mid_sel: got %b expected 1000", bus.psel_slv); end
    #1 presetn = 1'b0;
    #1;
    m_err = 0; m_tmo = '0;
    checks++; if (bus.psel_slv !== 4'b0) begin errors++; $display("FAIL mid_rst_psel: got %b expected 0000", bus.psel_slv); end
    checks++; if ({bus.pready_cpu, bus.pslverr_cpu, bus.tmo_irq} !== 3'b0) begin errors++; $display("FAIL mid_rst_ctl: got %b expected 000", {bus.pready_cpu, bus.pslverr_cpu, bus.tmo_irq}); end
    checks++; if (bus.err_cnt !== 16'h0) begin errors++; $display("FAIL mid_rst_err_cnt: got %0d expected 0", bus.err_cnt); end
    checks++; if (bus.tmo_slv !== 4'b0) begin errors++; $display("FAIL mid_rst_tmo: got %b expected 0000", bus.tmo_slv); end
    @(posedge pclk); #1;
    presetn = 1'b1; bus.psel_cpu = 1'b0; bus.penable_cpu = 1'b0;
    run_xfer(16'h0C00, 0, 1'b0, 32'h5555_AAAA, 0, o);
    checks++; if (o.cycles !== 1) begin errors++; $display("FAIL mid_after_cycles: got %0d expected 1", o.cycles); end
    checks++; if (o.rdata !== 32'h5555_AAAA) begin errors++; $display("FAIL mid_after_rdata: got %h expected 5555aaaa", o.rdata); end
    idle(1);
  endtask

  task automatic unmapped_burst(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk); #1; bus.paddr = 16'h2000; bus.psel_cpu = 1'b1; bus.penable_cpu = 1'b0;
      @(posedge pclk); #1; bus.penable_cpu = 1'b1;
    end
    m_err += n;
    idle(1);
  endtask

  task automatic test_err_saturation;
    unmapped_burst(65534 - m_err);
    checks++; if (bus.err_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe: got %h expected fffe", bus.err_cnt); end
    unmapped_burst(1);
    checks++; if (bus.err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff: got %h expected ffff", bus.err_cnt); end
    unmapped_burst(3);
    checks++; if (bus.err_cnt !== sat16(m_err)) begin errors++; $display("FAIL sat_hold: got %h expected %h", bus.err_cnt, sat16(m_err)); end
  endtask

  initial begin
    bus.paddr = '0; bus.psel_cpu = 1'b0; bus.penable_cpu = 1'b0; bus.clr_tmo = 1'b0;
    bus.prdata_slv = '0; bus.pready_slv = '0; bus.pslverr_slv = '0;
    test_reset();
    test_read();
    test_wait_states();
    test_unmapped();
    test_timeout();
    test_clr_collision();
    test_back_to_back();
    test_reset_mid();
    test_err_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
